pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB). It carries one generic control bundle and one generic data bundle per transaction, using a valid/ready handshake instead of EN/CLR. A 2-entry skid buffer keeps in_ready registered, so stalls do not create long combinational ready paths across stages. Flush inserts a bubble with zeroed control. A saturating stall counter supports performance debug.

Parameters:
CTRL_W, 12, width of control bundle (RegWrite, MemtoReg, link, ByteControl, …); forced to 0 on bubbles
DATA_W, 96, width of data bundle (e.g. ALU result, write-reg index, PC+4 concatenated); not masked
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; empties the stage
in_valid  in  1  upstream transaction valid
in_ready  out  1  stage can accept; registered output
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream transaction valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  out  DATA_W  data bundle; value when out_valid=0 is don't-care (holds last value)
occupancy  out  2  entries held, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Event definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (async, rst=1): state EMPTY; in_ready=1; out_valid=0; out_ctrl=0; main/skid data regs=0; occupancy=0; stall_cnt=0.
- Storage: main entry drives the outputs; skid entry holds overflow.
- States:
  - EMPTY: out_valid=0; occupancy=0.
  - FULL: main valid; occupancy=1.
  - SKID: main and skid both valid; occupancy=2.
- Transitions when flush=0:
  - EMPTY: accept -> FULL (main<=in); else stay.
  - FULL, accept & pop: stay FULL (main<=in).
  - FULL, accept & !pop: -> SKID (skid<=in).
  - FULL, !accept & pop: -> EMPTY.
  - FULL, otherwise: stay.
  - SKID: in_ready=0, so no accept; pop -> FULL (main<=skid); else stay.
- in_ready is registered: in_ready <= (next_state != SKID). It is never a combinational function of out_ready.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 transaction/cycle while out_ready=1. No bubble on FULL->FULL.
- Ordering: strict FIFO; skid content always leaves before any newer input.
- Flush (flush=1 at a clock edge):
  - Next state EMPTY; in_ready<=1; out_ctrl=0 from the next cycle.
  - An accept in the same cycle is discarded. Upstream is flushed by the same hazard unit.
  - A pop in the same cycle counts as delivered.
  - Flush has priority over every transition.
- Control masking: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. A bubble can never assert RegWrite or a memory write downstream.
- stall_cnt: +1 on every cycle with out_valid & !out_ready; saturates at 2^CNT_W-1. Cleared only by rst, not by flush.
- Reset asserted mid-transfer: all contents lost immediately (async). in_ready=1 on the first edge after release.
- Illegal inputs: in_valid with X on data is permitted; data is never interpreted. in_valid may drop without accept (no upstream stability requirement).

Decomposition:
- Shared package pipe_pkg: state encoding (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2) and per-stage CTRL_W/DATA_W constants for IF/ID, ID/EX, EX/MEM and MEM/WB.
- One sub-module, pipe_sat_counter (CNT_W, inc, saturating), holds stall_cnt. The rest is a single always_ff state/data block plus output masking.

Test Plan:
- Reset/idle: assert rst mid-cycle -> outputs zero at once; after release in_ready=1, out_valid=0, occupancy=0, stall_cnt=0.
- Streaming: in_valid=1, out_ready=1, data 1..8 on consecutive cycles -> out_data 1..8 one cycle later, each once, no gaps; occupancy stays 1; stall_cnt=0.
- Skid fill: stage FULL holding A, out_ready=0, push B -> occupancy=2; in_ready=0 next cycle; C held off. Raise out_ready -> A, B, C delivered in order.
- Flush: SKID state with ctrl=12'hFFF, assert flush while in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the incoming word is never output.
- Stall counter: out_valid=1, out_ready=0 for 5 cycles with CNT_W=3 -> stall_cnt=5. Hold 4 more cycles -> stall_cnt saturates at 7. A flush leaves it at 7.
- Random: random in_valid/out_ready/flush for 10k cycles, scoreboard FIFO model -> no loss/duplication outside flushes; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: state encoding and per-stage bundle widths for pipe stages |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // IF/ID carries instruction and PC+4; no control decoded yet
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 133;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 101;

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_sat_counter: up-counter that sticks at its maximum value        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_skid: valid/ready pipeline register with 2-entry skid     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q,     state_d;
  logic              in_ready_q,  in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic pop;
  logic stall_inc;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the skid entry can move forward
          if (pop) begin
            state_d     = ST_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_SKID);
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    occupancy = (state_q == ST_SKID) ? 2'd2 : (state_q == ST_FULL) ? 2'd1 : 2'd0;
    stall_inc = out_valid & ~out_ready;
  end

  assign in_ready = in_ready_q;
  assign out_data = main_data_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_skid: vector table plus queue-model scoreboard         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int CTRL_W = 12;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  typedef struct {
    logic              iv;
    logic              ordy;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              ev;
    logic [1:0]        eocc;
    logic              erdy;
    logic [CNT_W-1:0]  estall;
    logic [DATA_W-1:0] edata;
  } vec_t;

  item_t            q[$];
  logic             m_rdy;
  logic [CNT_W-1:0] m_cnt;
  int               tests  = 0;
  int               failed = 0;
  vec_t             tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b1;
    m_cnt = '0;
  endtask

  task automatic compare_model();
    logic ev;
    ev = (q.size() > 0);
    chk("out_valid", {127'd0, out_valid}, {127'd0, ev});
    chk("occupancy", {126'd0, occupancy}, 128'(q.size()));
    chk("in_ready", {127'd0, in_ready}, {127'd0, m_rdy});
    chk("stall_cnt", {125'd0, stall_cnt}, {125'd0, m_cnt});
    if (ev) begin
      chk("out_ctrl", {116'd0, out_ctrl}, {116'd0, q[0].ctrl});
      chk("out_data", {32'd0, out_data}, {32'd0, q[0].data});
    end else begin
      chk("out_ctrl_bubble", {116'd0, out_ctrl}, 128'd0);
    end
  endtask

  // Applies one set of inputs across a rising edge, advances the model, checks.
  task automatic cycle(input logic iv, input logic fl, input logic ordy,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    logic acc;
    logic pp;
    item_t it;
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = d;
    @(posedge clk);
    acc = iv & m_rdy;
    pp  = (q.size() > 0) & ordy;
    if ((q.size() > 0) && !ordy && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        it.ctrl = c;
        it.data = d;
        q.push_back(it);
      end
    end
    m_rdy = (q.size() < 2);
    #1;
    compare_model();
  endtask

  initial begin
    // Skid fill: A held, B skids, C held off, then drained in order
    tbl[0] = '{1'b1, 1'b0, 12'h0A1, 96'hA, 1'b1, 2'd1, 1'b1, 3'd0, 96'hA};
    tbl[1] = '{1'b1, 1'b0, 12'h0B2, 96'hB, 1'b1, 2'd2, 1'b0, 3'd1, 96'hA};
    tbl[2] = '{1'b1, 1'b0, 12'h0C3, 96'hC, 1'b1, 2'd2, 1'b0, 3'd2, 96'hA};
    tbl[3] = '{1'b1, 1'b1, 12'h0C3, 96'hC, 1'b1, 2'd1, 1'b1, 3'd2, 96'hB};
    tbl[4] = '{1'b1, 1'b1, 12'h0C3, 96'hC, 1'b1, 2'd1, 1'b1, 3'd2, 96'hC};
    tbl[5] = '{1'b0, 1'b1, 12'h000, 96'h0, 1'b0, 2'd0, 1'b1, 3'd2, 96'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    compare_model();

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, CTRL_W'(i), DATA_W'(i));
      chk("stream_data", {32'd0, out_data}, 128'(i));
      chk("stream_occ", {126'd0, occupancy}, 128'd1);
    end
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    chk("stream_stall", {125'd0, stall_cnt}, 128'd0);

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].iv, 1'b0, tbl[i].ordy, tbl[i].c, tbl[i].d);
      chk("tbl_valid", {127'd0, out_valid}, {127'd0, tbl[i].ev});
      chk("tbl_occ", {126'd0, occupancy}, {126'd0, tbl[i].eocc});
      chk("tbl_rdy", {127'd0, in_ready}, {127'd0, tbl[i].erdy});
      chk("tbl_stall", {125'd0, stall_cnt}, {125'd0, tbl[i].estall});
      if (tbl[i].ev) chk("tbl_data", {32'd0, out_data}, {32'd0, tbl[i].edata});
    end

    // Asynchronous reset asserted mid-cycle while holding data
    cycle(1'b1, 1'b0, 1'b0, 12'h5A5, 96'h77);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_occ", {126'd0, occupancy}, 128'd0);
    chk("rst_ctrl", {116'd0, out_ctrl}, 128'd0);
    chk("rst_rdy", {127'd0, in_ready}, 128'd1);
    chk("rst_stall", {125'd0, stall_cnt}, 128'd0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Stall counter saturation, then flush out of SKID
    cycle(1'b1, 1'b0, 1'b0, 12'hFFF, 96'h111);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    chk("stall_5", {125'd0, stall_cnt}, 128'd5);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, '0);
    chk("stall_sat", {125'd0, stall_cnt}, 128'd7);
    cycle(1'b1, 1'b0, 1'b0, 12'hFFF, 96'h222);
    chk("skid_occ", {126'd0, occupancy}, 128'd2);
    chk("skid_rdy", {127'd0, in_ready}, 128'd0);
    cycle(1'b1, 1'b1, 1'b0, 12'hFFF, 96'h333);
    chk("flush_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_ctrl", {116'd0, out_ctrl}, 128'd0);
    chk("flush_occ", {126'd0, occupancy}, 128'd0);
    chk("flush_rdy", {127'd0, in_ready}, 128'd1);
    chk("flush_stall", {125'd0, stall_cnt}, 128'd7);
    cycle(1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_no_out", {127'd0, out_valid}, 128'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 2) != 0),
            CTRL_W'($urandom),
            {$urandom, $urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
